// File: rtl/bus_arbiter_if.sv
// Bus request/grant bundle between the source side and the arbiter.
// The slave modport is the arbiter's view; master is the requester side.
interface bus_arbiter_if #(
  parameter int unsigned NSRC = 24
) ();

  logic [NSRC-1:0] req;
  logic            done;
  logic [NSRC-1:0] grant;
  logic [4:0]      bus_sel;
  logic            busy;
  logic            timeout;

  modport slave (
    input  req,
    input  done,
    output grant,
    output bus_sel,
    output busy,
    output timeout
  );

  modport master (
    output req,
    output done,
    input  grant,
    input  bus_sel,
    input  busy,
    input  timeout
  );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround between owners and a
// bounded ownership length; grant, bus_sel, busy and timeout are registered.
module bus_arbiter #(
  parameter int unsigned NSRC = 24,
  parameter int unsigned TMO  = 16
) (
  input  logic          clock,
  input  logic          clear,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned IW = 5;
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [IW-1:0] SEL_NONE = 5'b11111;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic [IW-1:0]   bus_sel_q, bus_sel_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [NSRC-1:0] win_onehot;
  logic            owner_req;
  logic            cnt_last;
  logic            release_now;

  // Round-robin search: start just above the last owner and wrap at NSRC.
  always_comb begin : rr_search
    cand      = '0;
    win_idx   = SEL_NONE;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      cand = IW'((32'(ptr_q) + 32'(k)) % NSRC);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin : winner_decode
    win_onehot = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      win_onehot[i] = win_found && (IW'(i) == win_idx);
    end
  end

  // Owner's own request, taken through the grant mask so other sources never matter.
  assign owner_req   = |(bus.req & grant_q);
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign release_now = bus.done || !owner_req || cnt_last;

  always_comb begin : fsm_next
    state_d   = state_q;
    grant_d   = grant_q;
    bus_sel_d = bus_sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          state_d   = OWN;
          grant_d   = win_onehot;
          bus_sel_d = win_idx;
          busy_d    = 1'b1;
          ptr_d     = win_idx;
        end
      end

      OWN: begin
        if (release_now) begin
          // Forced revoke only when the owner still wants the bus and never released it.
          state_d   = TURN;
          grant_d   = '0;
          bus_sel_d = SEL_NONE;
          busy_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = cnt_last && !bus.done && owner_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      TURN: begin
        state_d   = IDLE;
        grant_d   = '0;
        bus_sel_d = SEL_NONE;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end

      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        bus_sel_d = SEL_NONE;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // Reset drops ownership immediately and re-arms source 0 as first priority.
  always_ff @(posedge clock) begin : state_reg
    if (!clear) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      bus_sel_q <= SEL_NONE;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= IW'(NSRC - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      bus_sel_q <= bus_sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.bus_sel = bus_sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

  a_grant_onehot : assert property (@(posedge clock) disable iff (!clear)
    $onehot0(grant_q));

  a_sel_range : assert property (@(posedge clock) disable iff (!clear)
    (bus_sel_q < IW'(NSRC)) || (bus_sel_q == SEL_NONE));

  a_busy_grant : assert property (@(posedge clock) disable iff (!clear)
    busy_q == (grant_q != '0));

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a cycle model predicts registered outputs,
// directed scenarios cover priority, wrap, timeout and reset, then random traffic.
module tb_bus_arbiter;

  localparam int NSRC = 24;
  localparam int TMO  = 16;

  typedef struct packed {
    logic [NSRC-1:0] grant;
    logic [4:0]      bus_sel;
    logic            busy;
    logic            timeout;
  } exp_t;

  logic clock = 1'b0;
  logic clear;

  bus_arbiter_if #(.NSRC(NSRC)) bus ();

  bus_arbiter #(.NSRC(NSRC), .TMO(TMO)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_state;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_tmo;

  logic [NSRC-1:0] prev_grant;
  int waitc[NSRC];
  int maxw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [NSRC-1:0] r, input logic d, input logic c);
    if (!c) begin
      m_state = 0; m_owner = -1; m_ptr = NSRC - 1; m_cnt = 0; m_tmo = 0;
    end else begin
      case (m_state)
        0: begin
          m_tmo = 0;
          if (r != '0) begin
            int i;
            i = m_ptr;
            do i = (i + 1) % NSRC; while (!r[i]);
            m_owner = i; m_ptr = i; m_cnt = 0; m_state = 1;
          end
        end
        1: begin
          if (d || !r[m_owner] || m_cnt == TMO - 1) begin
            m_tmo = !d && r[m_owner];
            m_owner = -1; m_cnt = 0; m_state = 2;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          m_tmo = 0; m_state = 0;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant   = (m_owner >= 0) ? (NSRC'(1) << m_owner) : '0;
    e.bus_sel = (m_owner >= 0) ? 5'(m_owner) : 5'h1f;
    e.busy    = (m_owner >= 0);
    e.timeout = m_tmo;
    return e;
  endfunction

  // One clock: predict, advance, then compare and run structural checks.
  task automatic step();
    exp_t e;
    logic [4:0] sel;
    model_step(bus.req, bus.done, clear);
    sb.push_back(model_out());
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("grant",   32'(bus.grant),   32'(e.grant));
    check("bus_sel", 32'(bus.bus_sel), 32'(e.bus_sel));
    check("busy",    32'(bus.busy),    32'(e.busy));
    check("timeout", 32'(bus.timeout), 32'(e.timeout));
    check("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    sel = 5'h1f;
    for (int i = 0; i < NSRC; i++) if (bus.grant[i]) sel = 5'(i);
    check("sel_vs_grant", 32'(bus.bus_sel), 32'(sel));
    if (prev_grant != '0 && bus.grant != '0)
      check("b2b_owner", 32'(bus.grant), 32'(prev_grant));
    prev_grant = bus.grant;
    for (int i = 0; i < NSRC; i++) begin
      if (!clear || !bus.req[i] || bus.grant[i]) waitc[i] = 0;
      else waitc[i]++;
      if (waitc[i] > maxw) maxw = waitc[i];
    end
  endtask

  task automatic do_reset();
    clear    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    step();
    step();
    clear = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int own;
    prev_grant = '0;
    maxw = 0;
    for (int i = 0; i < NSRC; i++) waitc[i] = 0;

    // Reset state
    do_reset();
    check("rst_grant",   32'(bus.grant),   32'h0);
    check("rst_bus_sel", 32'(bus.bus_sel), 32'h1f);
    check("rst_busy",    32'(bus.busy),    32'h0);

    // Single requester: r0 granted one cycle later
    bus.req = 24'h000001;
    step();
    check("t030_grant",   32'(bus.grant),   32'h000001);
    check("t030_bus_sel", 32'(bus.bus_sel), 32'd0);
    check("t030_busy",    32'(bus.busy),    32'd1);
    bus.req = '0;
    step();
    step();

    // r5 before PC, then PC after done and turnaround
    do_reset();
    bus.req = 24'h100020;
    step();
    check("t031_first", 32'(bus.bus_sel), 32'd5);
    bus.done = 1'b1;
    step();
    check("t031_turn", 32'(bus.grant), 32'h0);
    bus.done = 1'b0;
    step();
    check("t031_idle", 32'(bus.grant), 32'h0);
    step();
    check("t031_pc_sel",   32'(bus.bus_sel), 32'd20);
    check("t031_pc_grant", 32'(bus.grant),   32'h100000);
    bus.req = '0;
    step();
    step();

    // Wrap-around after C_sign owned the bus
    do_reset();
    bus.req = 24'h800000;
    step();
    check("t032_csign", 32'(bus.bus_sel), 32'd23);
    bus.req = '0;
    step();
    step();
    bus.req = 24'h800001;
    step();
    check("t032_r0", 32'(bus.bus_sel), 32'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    step();
    check("t032_wrap", 32'(bus.bus_sel), 32'd23);
    bus.req = '0;
    step();
    step();

    // Forced revoke after TMO cycles of ownership
    do_reset();
    bus.req = 24'h000003;
    own = 0;
    for (int k = 0; k < TMO + 1; k++) begin
      step();
      if (bus.grant == 24'h000001) own++;
    end
    check("t033_own_cycles", 32'(own), 32'(TMO));
    check("t033_tmo_hi",     32'(bus.timeout), 32'd1);
    check("t033_tmo_grant",  32'(bus.grant),   32'h0);
    step();
    check("t033_tmo_lo", 32'(bus.timeout), 32'd0);
    step();
    check("t033_next", 32'(bus.bus_sel), 32'd1);
    bus.req = '0;
    step();
    step();

    // Reset in the middle of MDR ownership
    do_reset();
    bus.req = 24'h200000;
    step();
    check("t034_mdr", 32'(bus.bus_sel), 32'd21);
    bus.req = 24'h200001;
    step();
    check("t034_hold", 32'(bus.bus_sel), 32'd21);
    clear = 1'b0;
    step();
    check("t034_grant",   32'(bus.grant),   32'h0);
    check("t034_bus_sel", 32'(bus.bus_sel), 32'h1f);
    check("t034_timeout", 32'(bus.timeout), 32'd0);
    clear = 1'b1;
    step();
    check("t034_r0", 32'(bus.bus_sel), 32'd0);

    // Random traffic with occasional resets
    for (int c = 0; c < 10000; c++) begin
      clear    = ($urandom_range(0, 999) != 0);
      bus.req  = bus.req ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      bus.done = ($urandom_range(0, 9) == 0);
      step();
    end

    check("starvation", 32'(maxw <= NSRC * (TMO + 2)), 32'd1);
    check("sb_empty",   32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NSRC, default 24, SHALL set the number of bus sources: r0-r15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C_sign at indices 0-23.
REQ-002 Parameter TMO, default 16, SHALL set the maximum ownership length in cycles before the grant is forcibly revoked.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clear  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 req  input  NSRC  SHALL carry per-source bus requests, level-sensitive, bit i = source i.
REQ-006 done  input  1  SHALL be the release strobe from the current owner, sampled only in OWN.
REQ-007 grant  output  NSRC  SHALL be a registered one-hot (or zero) bus-drive enable, one bit per source.
REQ-008 bus_sel  output  5  SHALL be the registered binary index of the asserted grant bit, 5'b11111 when grant is zero.
REQ-009 busy  output  1  SHALL be high whenever grant is non-zero.
REQ-010 timeout  output  1  SHALL pulse high for one cycle when an ownership is forcibly revoked.

Function
REQ-011 The block SHALL implement three states: IDLE, OWN and TURN (turnaround).
REQ-012 IDLE: if req is non-zero, the block SHALL select a winner and enter OWN; grant/bus_sel SHALL reflect the winner on the next clock edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at index ptr+1 and proceeds upward; after NSRC-1 it wraps to 0; the first set req bit wins.
REQ-014 ptr SHALL load the winner index when OWN is entered, and SHALL hold otherwise.
REQ-015 A source SHALL win again only if no other source requests, so the search reaches it last.
REQ-016 OWN: grant SHALL hold constant; the ownership counter SHALL increment each cycle from 0.
REQ-017 OWN SHALL exit to TURN on the first of: done=1, req[owner]=0, or the counter reaching TMO-1.
REQ-018 If done and the counter reaching TMO-1 coincide, the exit SHALL be a normal release and timeout SHALL stay low.
REQ-019 On a forced exit (counter reaching TMO-1 with done=0 and req[owner]=1), timeout SHALL be high for exactly the TURN cycle.
REQ-020 TURN SHALL last exactly one cycle with grant=0, bus_sel=5'b11111 and busy=0, then SHALL go to IDLE.
REQ-021 From IDLE with pending requests, the next grant SHALL appear one cycle later, giving a minimum gap of 2 cycles between grants.
REQ-022 At most one grant bit SHALL ever be high.
REQ-023 grant SHALL never change directly from one non-zero value to another; at least one zero cycle SHALL separate owners.
REQ-024 done SHALL be ignored in IDLE and TURN.
REQ-025 req changes of non-owners SHALL be ignored in OWN.
REQ-026 bus_sel SHALL be the index of the grant bit in every cycle, and SHALL never take values 24-30.

Reset
REQ-027 When clear=0 at a clock edge, the block SHALL set state=IDLE, grant=0, bus_sel=5'b11111, busy=0, timeout=0, counter=0 and ptr=NSRC-1, so that source 0 has first priority.
REQ-028 Reset asserted in OWN or TURN SHALL drop grant in that same edge, with no TURN cycle and no timeout pulse.
REQ-029 In the first cycle after clear returns high, the block SHALL behave as IDLE.

Verification
REQ-030 Reset, then req=0x000001 held -> grant=0x000001, bus_sel=0 one cycle later, busy=1.
REQ-031 req=0x100020 (PC, r5) from reset -> r5 granted first (bus_sel=5); done -> TURN, IDLE, then PC granted (bus_sel=20, grant=0x100000).
REQ-032 Wrap-around: ptr=23 (C_sign last owner), req=0x800001 -> r0 granted; next arbitration grants C_sign (bus_sel=23).
REQ-033 TMO=16, owner holds req and never asserts done -> grant drops after 16 OWN cycles, timeout=1 for exactly one cycle, next requester granted.
REQ-034 clear=0 mid-OWN while owner is MDR (bus_sel=21) -> next edge grant=0, bus_sel=5'b11111, timeout=0; after release, r0 wins if requesting.
REQ-035 Randomised req/done over 10k cycles -> grant always zero or one-hot, bus_sel consistent with grant, no back-to-back owner change, no source starved longer than NSRC*(TMO+2) cycles.
